flappy_game_ctrl: RTL and testbench
===================================

// Module: flappy_game_ctrl
// PURPOSE
//  Game sequencer for the bird datapath. Drives the bird's sync reset and up
//  inputs from the flap button. Runs the round FSM (idle/play/fall/over) from
//  collision and floor events. Keeps the current and best score. Sits between
//  the input synchronizers, the collision/pipe logic and the bird + display.
// PARAMETERS
//  FLAP_CYCLES  32   clk cycles bird_up is held per flap (>=1)
//  LOCKOUT      256  clk cycles in OVER before a flap is accepted (>=1)
//  FLOOR_H      10   bird height treated as floor contact (9-bit compare)
//  SCORE_W      10   score / best width; score saturates at all-ones
// PORTS
//  clk         in   1        system clock, same clock as bird
//  reset       in   1        asynchronous, active-low (asserted at 0)
//  flap        in   1        button level, already synchronized to clk
//  collide     in   1        pipe hit this cycle (level or pulse)
//  pass        in   1        1-cycle pulse: bird cleared a pipe
//  height      in   9        current bird height from bird
//  bird_reset  out  1        sync active-high reset to bird
//  bird_up     out  1        up command to bird
//  playing     out  1        1 in PLAY
//  game_over   out  1        1 in OVER
//  score       out  SCORE_W  current round score
//  best        out  SCORE_W  best score since reset
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, flap_q=0, burst=0, lock=0,
//    bird_reset=1, bird_up=0, playing=0, game_over=0, score=0, best=0.
//  - All outputs are registered.
//  - fl_edge = flap & ~flap_q; flap_q <= flap every cycle.
//  - IDLE: bird_reset=1, bird_up=0.
//    - On fl_edge at cycle N: state=PLAY, score=0 and burst=FLAP_CYCLES at N+1.
//    - At N+1: bird_reset=0, bird_up=1, playing=1.
//  - PLAY:
//    - bird_up=1 iff burst!=0; burst decrements while nonzero, so bird_up is
//      high exactly FLAP_CYCLES cycles.
//    - fl_edge reloads burst=FLAP_CYCLES (restart, no accumulation).
//    - pass: score+1, held at all-ones (no wrap).
//    - Priority, same cycle: height<=FLOOR_H -> OVER; else collide -> FALL.
//      A pass in a cycle where the round ends is dropped.
//  - FALL: bird_up=0, burst=0, flap/pass ignored. Next state is OVER once
//    height<=FLOOR_H.
//  - OVER:
//    - On entry: lock=LOCKOUT; if score>best then best=score (1 cycle after
//      entry, visible while game_over=1).
//    - bird_up=0, bird_reset=0, game_over=1, score held.
//    - lock decrements to 0; fl_edge is ignored while lock!=0.
//    - fl_edge with lock==0 -> IDLE (bird_reset=1 next cycle). A second flap
//      is needed to start the next round.
//  - A flap held across states does not re-trigger; only rising edges act.
//  - reset asserted mid-round: immediate return to reset values; best is
//    cleared.
//  - Unused state encodings -> IDLE on next clock.
// TESTING (bench overrides FLAP_CYCLES=4, LOCKOUT=8, FLOOR_H=10, SCORE_W=4)
//  1. reset=0 then 1, flap=0 -> bird_reset=1, bird_up=0, score=0, best=0,
//     state IDLE.
//  2. flap 0->1 at cycle N (held high 20 cycles) -> playing=1 and bird_up=1
//     on N+1..N+4, bird_up=0 from N+5; no retrigger while held.
//  3. In PLAY, second flap edge when burst=2 -> bird_up stays 1 for 4 more
//     cycles; 3 pass pulses -> score=3.
//  4. collide=1 with height=100 -> FALL, bird_up=0, flaps ignored.
//     height=10 -> game_over=1, best=3. Flap at lock=3 ignored; flap after 8
//     cycles -> IDLE.
//  5. 20 pass pulses with SCORE_W=4 -> score saturates at 15. Then
//     collide=1, pass=1 and height=10 in one cycle -> OVER directly, score=15.
//  6. reset=0 asynchronously mid-PLAY with bird_up=1 -> bird_up=0,
//     bird_reset=1, score=0, best=0 before the next clk edge.

Source files
------------

// File: rtl/flappy_game_ctrl_if.sv
// Bus between the game controller and its neighbours.
// Instantiate it with the same SCORE_W as the controller.
//   master : input side (synchronizers, pipe/collision logic); drives the
//            flap/collide/pass/height inputs and receives the outputs
//   slave  : the controller itself
//   flap       button level, already synchronized to clk
//   collide    pipe hit this cycle
//   pass       1-cycle pulse when the bird clears a pipe
//   height     current bird height
//   bird_reset sync active-high reset to the bird
//   bird_up    up command to the bird
//   playing    high while a round is in progress
//   game_over  high on the game-over screen
//   score      current round score
//   best       best score since reset
interface flappy_game_ctrl_if #(
  parameter int SCORE_W = 10
);
  logic               flap;
  logic               collide;
  logic               pass;
  logic [8:0]         height;
  logic               bird_reset;
  logic               bird_up;
  logic               playing;
  logic               game_over;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] best;

  modport master (
    output flap, collide, pass, height,
    input  bird_reset, bird_up, playing, game_over, score, best
  );

  modport slave (
    input  flap, collide, pass, height,
    output bird_reset, bird_up, playing, game_over, score, best
  );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Round sequencer for the bird datapath.
// Turns flap button edges into bird_up bursts, runs the round through
// IDLE -> PLAY -> (FALL) -> OVER -> IDLE, and keeps current/best score.
// Ports:
//   clk    system clock, shared with the bird
//   reset  asynchronous, active-low
//   bus    flappy_game_ctrl_if.slave (flap/collide/pass/height in,
//          bird_reset/bird_up/playing/game_over/score/best out)
// Every output is a register loaded from the next-state values, so the
// outputs change on the same edge as the state they describe.
module flappy_game_ctrl #(
  parameter int FLAP_CYCLES = 32,
  parameter int LOCKOUT     = 256,
  parameter int FLOOR_H     = 10,
  parameter int SCORE_W     = 10
) (
  input  logic               clk,
  input  logic               reset,
  flappy_game_ctrl_if.slave  bus
);
  localparam int BW = $clog2(FLAP_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT + 1);

  typedef enum logic [1:0] {IDLE, PLAY, FALL, OVER} state_t;

  state_t             state, state_n;
  logic               flap_q;
  logic [BW-1:0]      burst, burst_n;
  logic [LW-1:0]      lock, lock_n;
  logic [SCORE_W-1:0] score, score_n, best, best_n;
  logic               bird_reset_q, bird_up_q, playing_q, game_over_q;
  logic               fl_edge, floor_hit;

  assign fl_edge   = bus.flap & ~flap_q;
  assign floor_hit = bus.height <= 9'(FLOOR_H);

  always_comb begin
    state_n = state;
    burst_n = burst;
    lock_n  = lock;
    score_n = score;
    best_n  = best;
    case (state)
      IDLE: begin
        if (fl_edge) begin
          state_n = PLAY;
          score_n = '0;
          burst_n = BW'(FLAP_CYCLES);
        end
      end
      PLAY: begin
        // A new edge restarts the burst rather than adding to it.
        if (fl_edge)             burst_n = BW'(FLAP_CYCLES);
        else if (burst != '0)    burst_n = burst - BW'(1);
        // Floor beats collide; a pass on the ending cycle is dropped.
        if (floor_hit) begin
          state_n = OVER;
          lock_n  = LW'(LOCKOUT);
          burst_n = '0;
        end else if (bus.collide) begin
          state_n = FALL;
          burst_n = '0;
        end else if (bus.pass && (score != '1)) begin
          score_n = score + SCORE_W'(1);
        end
      end
      FALL: begin
        burst_n = '0;
        if (floor_hit) begin
          state_n = OVER;
          lock_n  = LW'(LOCKOUT);
        end
      end
      OVER: begin
        // Score is frozen here, so best settles one cycle after entry.
        if (score > best) best_n = score;
        if (lock != '0)   lock_n  = lock - LW'(1);
        else if (fl_edge) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      flap_q       <= 1'b0;
      burst        <= '0;
      lock         <= '0;
      score        <= '0;
      best         <= '0;
      bird_reset_q <= 1'b1;
      bird_up_q    <= 1'b0;
      playing_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state        <= state_n;
      flap_q       <= bus.flap;
      burst        <= burst_n;
      lock         <= lock_n;
      score        <= score_n;
      best         <= best_n;
      bird_reset_q <= (state_n == IDLE);
      bird_up_q    <= (state_n == PLAY) && (burst_n != '0);
      playing_q    <= (state_n == PLAY);
      game_over_q  <= (state_n == OVER);
    end
  end

  assign bus.bird_reset = bird_reset_q;
  assign bus.bird_up    = bird_up_q;
  assign bus.playing    = playing_q;
  assign bus.game_over  = game_over_q;
  assign bus.score      = score;
  assign bus.best       = best;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl (FLAP_CYCLES=4, LOCKOUT=8,
// FLOOR_H=10, SCORE_W=4): directed scenarios with literal expectations,
// then random play, all compared every cycle against a behavioural model.
module tb_flappy_game_ctrl;
  localparam int FC = 4, LK = 8, FH = 10, SW = 4, SMAX = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0, n_fail = 0;
  bit   chk_en = 0;

  flappy_game_ctrl_if #(.SCORE_W(SW)) bus ();

  flappy_game_ctrl #(
    .FLAP_CYCLES(FC), .LOCKOUT(LK), .FLOOR_H(FH), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: round phase 0=idle 1=play 2=fall 3=over,
  // remaining up cycles, remaining lockout, scores.
  int m_mode, m_up, m_lock, m_score, m_best;
  bit m_fq, m_e, m_fl;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_up = 0; m_lock = 0; m_score = 0; m_best = 0; m_fq = 0;
    end else begin
      m_e  = bus.flap && !m_fq;
      m_fq = bus.flap;
      m_fl = (bus.height <= FH);
      case (m_mode)
        0: if (m_e) begin m_mode = 1; m_score = 0; m_up = FC; end
        1: begin
          if (m_fl) begin m_mode = 3; m_lock = LK; end
          else if (bus.collide) m_mode = 2;
          else begin
            if (m_e) m_up = FC;
            else if (m_up > 0) m_up--;
            if (bus.pass && m_score < SMAX) m_score++;
          end
        end
        2: if (m_fl) begin m_mode = 3; m_lock = LK; end
        default: begin
          if (m_score > m_best) m_best = m_score;
          if (m_lock > 0) m_lock--;
          else if (m_e) m_mode = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      chk("m_bird_reset", bus.bird_reset, m_mode == 0);
      chk("m_bird_up",    bus.bird_up,    (m_mode == 1) && (m_up > 0));
      chk("m_playing",    bus.playing,    m_mode == 1);
      chk("m_game_over",  bus.game_over,  m_mode == 3);
      chk("m_score",      bus.score,      m_score);
      chk("m_best",       bus.best,       m_best);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.flap = 0; bus.collide = 0; bus.pass = 0; bus.height = 9'd100;
    #12;
    chk("rst_bird_reset", bus.bird_reset, 1);
    chk("rst_bird_up",    bus.bird_up,    0);
    chk("rst_game_over",  bus.game_over,  0);
    @(posedge clk); #1 reset = 1; chk_en = 1;
    step(2);
    chk("idle_bird_reset", bus.bird_reset, 1);
    chk("idle_score",      bus.score,      0);
    chk("idle_best",       bus.best,       0);
    chk("idle_playing",    bus.playing,    0);

    // First round start, flap held 20 cycles.
    bus.flap = 1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk($sformatf("start_up_%0d", k), bus.bird_up, (k <= 4) ? 1 : 0);
      if (k == 1) chk("start_playing", bus.playing, 1);
    end
    step(15);
    chk("held_no_retrigger", bus.bird_up, 0);
    bus.flap = 0; step(1);

    // Reload while burst is 2.
    bus.flap = 1; step(1); bus.flap = 0; step(2);
    bus.flap = 1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk($sformatf("reload_up_%0d", k), bus.bird_up, (k <= 4) ? 1 : 0);
      bus.flap = 0;
    end
    repeat (3) begin bus.pass = 1; step(1); bus.pass = 0; step(1); end
    chk("score_3", bus.score, 3);

    // Collide -> fall, flaps ignored, floor -> over.
    bus.collide = 1; step(1); bus.collide = 0;
    chk("fall_playing", bus.playing, 0);
    chk("fall_up",      bus.bird_up, 0);
    bus.flap = 1; step(1); bus.flap = 0; step(1);
    chk("fall_flap_ign", bus.game_over, 0);
    bus.height = 9'd10; step(1); bus.height = 9'd100;
    chk("over_entry", bus.game_over, 1);
    step(1);
    chk("best_3", bus.best, 3);
    step(4);                       // lock now 3
    bus.flap = 1; step(1); bus.flap = 0;
    chk("lock_flap_ign", bus.game_over, 1);
    step(8);
    bus.flap = 1; step(1); bus.flap = 0;
    chk("over_to_idle", bus.bird_reset, 1);
    chk("idle_no_over", bus.game_over, 0);
    step(1);

    // Saturation, then simultaneous collide/pass/floor.
    bus.flap = 1; step(1); bus.flap = 0;
    repeat (20) begin bus.pass = 1; step(1); bus.pass = 0; step(1); end
    chk("score_sat", bus.score, 15);
    bus.collide = 1; bus.pass = 1; bus.height = 9'd10; step(1);
    bus.collide = 0; bus.pass = 0; bus.height = 9'd100;
    chk("direct_over", bus.game_over, 1);
    chk("direct_score", bus.score, 15);
    step(1);
    chk("best_15", bus.best, 15);
    step(10);
    bus.flap = 1; step(1); bus.flap = 0; step(1);

    // Async reset mid-play.
    bus.flap = 1; step(1); bus.flap = 0;
    chk("pre_rst_up", bus.bird_up, 1);
    #2 reset = 0;
    #1;
    chk("async_up",         bus.bird_up,    0);
    chk("async_bird_reset", bus.bird_reset, 1);
    chk("async_score",      bus.score,      0);
    chk("async_best",       bus.best,       0);
    @(posedge clk); #1 reset = 1;
    step(1);

    // Random play.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) bus.flap = ~bus.flap;
      bus.collide = ($urandom_range(39) == 0);
      bus.pass    = ($urandom_range(3) == 0);
      bus.height  = ($urandom_range(24) == 0) ? 9'($urandom_range(10))
                                              : 9'($urandom_range(511, 11));
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
